// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl - MEM-stage sequencer for the 5-stage MIPS pipeline.
// Converts the EX/MEM load/store request into one req/ack bus transaction
// against a variable-latency data memory, freezes the pipeline with stall
// until the access completes or times out, and keeps sticky error status
// plus wrapping read/write completion counters.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   Mem_Read, Mem_Write        load/store request from EX/MEM
//   Address, Write_Data        byte address and store data from EX/MEM
//   mem_ack, mem_rdata         memory completion strobe and read data
//   mem_req, mem_we            registered bus request and direction
//   mem_addr, mem_wdata        latched address and store data
//   Read_Data, rd_valid        load result to MEM/WB and its valid flag
//   stall                      pipeline freeze (combinational)
//   bus_error                  sticky error (illegal request or timeout)
//   rd_cnt, wr_cnt             completed reads / writes, wrapping
module mem_access_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Mem_Read,
  input  logic              Mem_Write,
  input  logic [DATA_W-1:0] Address,
  input  logic [DATA_W-1:0] Write_Data,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] Read_Data,
  output logic              rd_valid,
  output logic              stall,
  output logic              bus_error,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nx;
  logic [7:0] wait_cnt;
  logic       one_req;
  logic       both_req;
  logic       timeout_hit;

  always_comb begin
    one_req     = Mem_Read ^ Mem_Write;
    both_req    = Mem_Read & Mem_Write;
    timeout_hit = (wait_cnt == WAIT_LAST);
    state_nx    = state;
    stall       = 1'b0;
    case (state)
      IDLE: begin
        stall = one_req;
        if (one_req) state_nx = REQ;
      end
      REQ: begin
        stall = 1'b1;
        if (mem_ack || timeout_hit) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // While reset is held the pipeline must not be frozen, even though the
    // IDLE decode would otherwise follow the (possibly active) request inputs.
    if (!rst_n) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      Read_Data <= '0;
      rd_valid  <= 1'b0;
      bus_error <= 1'b0;
      wait_cnt  <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (one_req) begin
            mem_addr  <= Address;
            mem_wdata <= Write_Data;
            mem_we    <= Mem_Write;
            mem_req   <= 1'b1;
            wait_cnt  <= '0;
          end else if (both_req) begin
            bus_error <= 1'b1;
          end
        end
        REQ: begin
          // Ack is tested first so it wins over a same-cycle timeout.
          if (mem_ack) begin
            mem_req  <= 1'b0;
            rd_valid <= ~mem_we;
            if (mem_we) begin
              wr_cnt <= wr_cnt + 1'b1;
            end else begin
              Read_Data <= mem_rdata;
              rd_cnt    <= rd_cnt + 1'b1;
            end
          end else if (timeout_hit) begin
            mem_req   <= 1'b0;
            bus_error <= 1'b1;
            rd_valid  <= ~mem_we;
            if (!mem_we) Read_Data <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE:    rd_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: a transaction-level reference model predicts
// stall/request durations, load data, counters and the sticky error flag for
// each load/store, while a memory responder acks on a chosen REQ cycle (or
// never, to force a timeout).
module tb_mem_access_ctrl;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              Mem_Read, Mem_Write;
  logic [DATA_W-1:0] Address, Write_Data;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_req, mem_we;
  logic [DATA_W-1:0] mem_addr, mem_wdata, Read_Data;
  logic              rd_valid, stall, bus_error;
  logic [CNT_W-1:0]  rd_cnt, wr_cnt;

  mem_access_ctrl #(
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Mem_Read  (Mem_Read),
    .Mem_Write (Mem_Write),
    .Address   (Address),
    .Write_Data(Write_Data),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .Read_Data (Read_Data),
    .rd_valid  (rd_valid),
    .stall     (stall),
    .bus_error (bus_error),
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state (transaction level).
  int          exp_rd;
  int          exp_wr;
  logic        exp_err;
  logic [31:0] exp_rdata;

  typedef struct {
    int          stall_n;
    int          req_n;
    int          unstable;
    bit          hung;
    logic        rv;
    logic [31:0] rd;
    logic [CNT_W-1:0] rc;
    logic [CNT_W-1:0] wc;
    logic        err;
    logic        req;
  } obs_t;

  function automatic bit acked(input int k);
    return (k >= 1 && k <= TIMEOUT);
  endfunction

  function automatic int req_len(input int k);
    return acked(k) ? k : TIMEOUT;
  endfunction

  function automatic void model_reset();
    exp_rd = 0; exp_wr = 0; exp_err = 1'b0; exp_rdata = '0;
  endfunction

  function automatic void model_update(input bit wr, input int k, input logic [31:0] rdata);
    if (acked(k)) begin
      if (wr) exp_wr++;
      else begin exp_rd++; exp_rdata = rdata; end
    end else begin
      exp_err = 1'b1;
      if (!wr) exp_rdata = '0;
    end
  endfunction

  // Drives one access starting in an IDLE cycle (called at posedge+1), acks
  // on REQ cycle k (k=0: never), snapshots outputs in the DONE cycle and
  // returns at posedge+1 of the following IDLE cycle with request inputs low.
  task automatic run_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int k, input logic [31:0] rdata, output obs_t o);
    bit done = 0;
    o = '{stall_n: 0, req_n: 0, unstable: 0, hung: 0, rv: 0, rd: '0, rc: '0, wc: '0, err: 0, req: 0};
    Mem_Read = !wr; Mem_Write = wr; Address = addr; Write_Data = wdata; mem_ack = 1'b0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (!stall) begin
        o.rv = rd_valid; o.rd = Read_Data; o.rc = rd_cnt; o.wc = wr_cnt;
        o.err = bus_error; o.req = mem_req;
        done = 1;
        break;
      end
      o.stall_n++;
      if (mem_req) begin
        o.req_n++;
        if (mem_addr !== addr || mem_wdata !== wdata || mem_we !== wr) o.unstable++;
        mem_ack   = (o.req_n == k);
        mem_rdata = (o.req_n == k) ? rdata : $urandom;
      end else begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      @(posedge clk);
    end
    if (!done) o.hung = 1;
    // DONE cycle: request inputs still held and a stray ack, both to be ignored.
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    @(posedge clk); #1;
    Mem_Read = 1'b0; Mem_Write = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    Mem_Read = 1'($urandom); Mem_Write = 1'($urandom); Address = $urandom;
    Write_Data = $urandom; mem_ack = 1'($urandom); mem_rdata = $urandom;
    repeat (2) @(posedge clk);
    #1;
    total++; if (mem_req !== 1'b0)   begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    total++; if (mem_we !== 1'b0)    begin bad++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    total++; if (mem_addr !== '0)    begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    total++; if (mem_wdata !== '0)   begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    total++; if (Read_Data !== '0)   begin bad++; $display("FAIL reset_read_data got=%h exp=0", Read_Data); end
    total++; if (rd_valid !== 1'b0)  begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    total++; if (stall !== 1'b0)     begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    total++; if (bus_error !== 1'b0) begin bad++; $display("FAIL reset_bus_error got=%b exp=0", bus_error); end
    total++; if (rd_cnt !== '0)      begin bad++; $display("FAIL reset_rd_cnt got=%0d exp=0", rd_cnt); end
    total++; if (wr_cnt !== '0)      begin bad++; $display("FAIL reset_wr_cnt got=%0d exp=0", wr_cnt); end
    Mem_Read = 1'b0; Mem_Write = 1'b0; mem_ack = 1'b0;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    obs_t o;
    run_access(1'b0, 32'h0000_0040, 32'h0, 3, 32'hCAFE_F00D, o);
    model_update(1'b0, 3, 32'hCAFE_F00D);
    total++; if (o.hung)             begin bad++; $display("FAIL load_hang got=1 exp=0"); end
    total++; if (o.stall_n != 4)     begin bad++; $display("FAIL load_stall_cycles got=%0d exp=4", o.stall_n); end
    total++; if (o.req_n != 3)       begin bad++; $display("FAIL load_req_cycles got=%0d exp=3", o.req_n); end
    total++; if (o.unstable != 0)    begin bad++; $display("FAIL load_addr_we_stable got=%0d exp=0", o.unstable); end
    total++; if (o.rd !== 32'hCAFEF00D) begin bad++; $display("FAIL load_read_data got=%h exp=cafef00d", o.rd); end
    total++; if (o.rv !== 1'b1)      begin bad++; $display("FAIL load_rd_valid got=%b exp=1", o.rv); end
    total++; if (o.rc !== CNT_W'(exp_rd)) begin bad++; $display("FAIL load_rd_cnt got=%0d exp=%0d", o.rc, CNT_W'(exp_rd)); end
    total++; if (rd_valid !== 1'b0)  begin bad++; $display("FAIL load_rd_valid_clear got=%b exp=0", rd_valid); end
  endtask

  task automatic test_store();
    obs_t o;
    run_access(1'b1, 32'h0000_0080, 32'h1234_5678, 1, 32'h0, o);
    model_update(1'b1, 1, 32'h0);
    total++; if (o.hung)             begin bad++; $display("FAIL store_hang got=1 exp=0"); end
    total++; if (o.stall_n != 2)     begin bad++; $display("FAIL store_stall_cycles got=%0d exp=2", o.stall_n); end
    total++; if (o.unstable != 0)    begin bad++; $display("FAIL store_addr_wdata_we got=%0d exp=0", o.unstable); end
    total++; if (o.wc !== CNT_W'(exp_wr)) begin bad++; $display("FAIL store_wr_cnt got=%0d exp=%0d", o.wc, CNT_W'(exp_wr)); end
    total++; if (o.rv !== 1'b0)      begin bad++; $display("FAIL store_rd_valid got=%b exp=0", o.rv); end
    total++; if (o.rd !== exp_rdata) begin bad++; $display("FAIL store_read_data_kept got=%h exp=%h", o.rd, exp_rdata); end
  endtask

  task automatic test_stray_ack();
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1'b1; mem_rdata = $urandom;
      @(posedge clk); #1;
      total++;
      if (mem_req !== 1'b0 || stall !== 1'b0 || rd_valid !== 1'b0 || Read_Data !== exp_rdata ||
          rd_cnt !== CNT_W'(exp_rd) || wr_cnt !== CNT_W'(exp_wr) || bus_error !== exp_err) begin
        bad++;
        $display("FAIL stray_ack req=%b stall=%b rv=%b rd=%h rc=%0d wc=%0d err=%b exp req=0 stall=0 rv=0 rd=%h rc=%0d wc=%0d err=%b",
                 mem_req, stall, rd_valid, Read_Data, rd_cnt, wr_cnt, bus_error,
                 exp_rdata, CNT_W'(exp_rd), CNT_W'(exp_wr), exp_err);
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_random_traffic(input int n, input bit allow_timeout);
    obs_t o;
    bit wr; int k; logic [31:0] a, d, r;
    for (int i = 0; i < n; i++) begin
      wr = 1'($urandom); a = $urandom; d = $urandom; r = $urandom;
      if (allow_timeout && $urandom_range(0, 4) == 0) k = 0;
      else k = $urandom_range(1, TIMEOUT);
      run_access(wr, a, d, k, r, o);
      model_update(wr, k, r);
      total++; if (o.hung || o.stall_n != 1 + req_len(k) || o.req_n != req_len(k) || o.unstable != 0 || o.req !== 1'b0) begin
        bad++;
        $display("FAIL rand_timing #%0d k=%0d hung=%0d stall=%0d req=%0d unstable=%0d req_done=%b exp stall=%0d req=%0d",
                 i, k, o.hung, o.stall_n, o.req_n, o.unstable, o.req, 1 + req_len(k), req_len(k));
      end
      total++; if (o.rv !== !wr || o.rd !== exp_rdata) begin
        bad++; $display("FAIL rand_read #%0d rv=%b rd=%h exp rv=%b rd=%h", i, o.rv, o.rd, !wr, exp_rdata);
      end
      total++; if (o.rc !== CNT_W'(exp_rd) || o.wc !== CNT_W'(exp_wr) || o.err !== exp_err) begin
        bad++; $display("FAIL rand_status #%0d rc=%0d wc=%0d err=%b exp rc=%0d wc=%0d err=%b",
                        i, o.rc, o.wc, o.err, CNT_W'(exp_rd), CNT_W'(exp_wr), exp_err);
      end
    end
  endtask

  task automatic test_illegal();
    Mem_Read = 1'b1; Mem_Write = 1'b1; Address = $urandom;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL illegal_stall got=%b exp=0", stall); end
    @(posedge clk); #1;
    exp_err = 1'b1;
    total++; if (bus_error !== 1'b1) begin bad++; $display("FAIL illegal_bus_error got=%b exp=1", bus_error); end
    total++; if (mem_req !== 1'b0)   begin bad++; $display("FAIL illegal_mem_req got=%b exp=0", mem_req); end
    total++; if (stall !== 1'b0)     begin bad++; $display("FAIL illegal_stall_after got=%b exp=0", stall); end
    Mem_Read = 1'b0; Mem_Write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_req();
    int seen = 0;
    Mem_Read = 1'b1; Mem_Write = 1'b0; Address = $urandom; mem_ack = 1'b0;
    for (int c = 0; c < 20 && seen < 2; c++) begin
      @(posedge clk); #1;
      if (mem_req === 1'b1) seen++;
    end
    total++; if (seen != 2) begin bad++; $display("FAIL midreq_reach got=%0d exp=2", seen); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL midreq_mem_req got=%b exp=0", mem_req); end
    total++; if (stall !== 1'b0)   begin bad++; $display("FAIL midreq_stall got=%b exp=0", stall); end
    total++; if (rd_cnt !== '0 || wr_cnt !== '0) begin bad++; $display("FAIL midreq_counters rc=%0d wc=%0d exp 0 0", rd_cnt, wr_cnt); end
    total++; if (bus_error !== 1'b0 || Read_Data !== '0 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL midreq_status err=%b rd=%h rv=%b exp 0 0 0", bus_error, Read_Data, rd_valid);
    end
    Mem_Read = 1'b0;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    obs_t o;
    logic [CNT_W-1:0] rc_before;
    rc_before = CNT_W'(exp_rd);
    run_access(1'b0, 32'h0000_0100, 32'h0, 0, 32'h0, o);
    model_update(1'b0, 0, 32'h0);
    total++; if (o.req_n != TIMEOUT) begin bad++; $display("FAIL timeout_req_cycles got=%0d exp=%0d", o.req_n, TIMEOUT); end
    total++; if (o.stall_n != TIMEOUT + 1) begin bad++; $display("FAIL timeout_stall got=%0d exp=%0d", o.stall_n, TIMEOUT + 1); end
    total++; if (o.req !== 1'b0 || o.err !== 1'b1) begin bad++; $display("FAIL timeout_flags req=%b err=%b exp 0 1", o.req, o.err); end
    total++; if (o.rd !== '0) begin bad++; $display("FAIL timeout_read_data got=%h exp=0", o.rd); end
    total++; if (o.rc !== rc_before) begin bad++; $display("FAIL timeout_rd_cnt got=%0d exp=%0d", o.rc, rc_before); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus_error !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b exp=1", bus_error); end
    run_access(1'b0, 32'h0000_0104, 32'h0, 2, 32'hA5A5_0001, o);
    model_update(1'b0, 2, 32'hA5A5_0001);
    total++; if (o.hung || o.stall_n != 3 || o.rd !== 32'hA5A5_0001 || o.rv !== 1'b1) begin
      bad++; $display("FAIL after_timeout_load stall=%0d rd=%h rv=%b exp 3 a5a50001 1", o.stall_n, o.rd, o.rv);
    end
    total++; if (o.rc !== CNT_W'(exp_rd) || o.err !== 1'b1) begin
      bad++; $display("FAIL after_timeout_status rc=%0d err=%b exp %0d 1", o.rc, o.err, CNT_W'(exp_rd));
    end
  endtask

  task automatic test_counter_wrap();
    obs_t o;
    int k;
    logic [31:0] r;
    bit saw_max = 0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < (1 << CNT_W); i++) begin
      k = $urandom_range(1, 3); r = $urandom;
      run_access(1'b0, $urandom, $urandom, k, r, o);
      model_update(1'b0, k, r);
      if (o.rc === {CNT_W{1'b1}}) saw_max = 1;
      total++; if (o.hung || o.rc !== CNT_W'(exp_rd) || o.rd !== exp_rdata) begin
        bad++; $display("FAIL wrap_load #%0d rc=%0d rd=%h exp rc=%0d rd=%h", i, o.rc, o.rd, CNT_W'(exp_rd), exp_rdata);
      end
    end
    total++; if (!saw_max) begin bad++; $display("FAIL wrap_max_seen got=0 exp=1"); end
    total++; if (rd_cnt !== '0) begin bad++; $display("FAIL wrap_rd_cnt got=%0d exp=0", rd_cnt); end
    total++; if (bus_error !== 1'b0) begin bad++; $display("FAIL wrap_no_flag got=%b exp=0", bus_error); end
  endtask

  initial begin
    rst_n = 1'b1;
    Mem_Read = 1'b0; Mem_Write = 1'b0; Address = '0; Write_Data = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_load();
    test_store();
    test_stray_ack();
    test_random_traffic(40, 1'b0);
    test_illegal();
    test_reset_mid_req();
    test_timeout();
    test_random_traffic(40, 1'b1);
    test_stray_ack();
    test_counter_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
